// File: rtl/vminmax_reduce.sv
// rtl/vminmax_reduce.sv - pipelined vector min/max: element-wise compare and multi-beat reduction
// Optional feature macro VMINMAX_64BIT_EN enables 64-bit elements (sew = 3).
module vminmax_reduce #(
  parameter int DATA_WIDTH = 64,
  parameter int SEW_WIDTH  = 2,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic                  red_mode,
  input  logic                  is_max,
  input  logic                  is_signed,
  input  logic [SEW_WIDTH-1:0]  sew,
  input  logic [DATA_WIDTH-1:0] vec0,
  input  logic [DATA_WIDTH-1:0] vec1,
  input  logic [BE_WIDTH-1:0]   in_be,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] minmax_result,
  output logic [BE_WIDTH-1:0]   lt,
  output logic [BE_WIDTH-1:0]   equal,
  output logic                  busy
);
  localparam int XW = DATA_WIDTH + 1;
`ifdef VMINMAX_64BIT_EN
  localparam int MAX_LG = 6;
`else
  localparam int MAX_LG = 5;
`endif
  localparam logic [DATA_WIDTH-1:0] DW_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BE_WIDTH-1:0]   BE_ONE = {{(BE_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;
  state_t state, state_nxt;

  // log2 of the element width in bits
  function automatic int elem_lg(input logic [SEW_WIDTH-1:0] s);
    int si;
    si = int'(s);
    return (si >= 3) ? MAX_LG : 3 + si;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] elem_mask(input int lg);
    return {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - (1 << lg));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] elem_get(input logic [DATA_WIDTH-1:0] v, input int lg, input int k);
    return (v >> (k << lg)) & elem_mask(lg);
  endfunction

  function automatic logic elem_active(input logic [BE_WIDTH-1:0] be, input int lg, input int k);
    return (be & (BE_ONE << (k << (lg - 3)))) != '0;
  endfunction

  // (SEW+1)-style extension carried at full width so every SEW shares one comparator
  function automatic logic signed [XW-1:0] elem_ext(input logic [DATA_WIDTH-1:0] x, input int lg, input logic sgn);
    logic [XW-1:0] r;
    logic          sb;
    sb = sgn && ((x & (DW_ONE << ((1 << lg) - 1))) != '0);
    r  = {1'b0, x & elem_mask(lg)};
    if (sb) r = r | ~{1'b0, elem_mask(lg)};
    return signed'(r);
  endfunction

  function automatic logic better(input logic signed [XW-1:0] x, input logic signed [XW-1:0] y, input logic mx);
    return mx ? (x > y) : (x < y);
  endfunction

  logic                 first_beat, red_beat;
  logic [SEW_WIDTH-1:0] lat_sew, c_sew;
  logic                 lat_max, lat_sgn, c_max, c_sgn;

  assign first_beat = (state == IDLE);
  assign red_beat   = in_valid && red_mode;
  assign c_sew      = first_beat ? sew : lat_sew;
  assign c_max      = first_beat ? is_max : lat_max;
  assign c_sgn      = first_beat ? is_signed : lat_sgn;
  assign busy       = (state == ACCUM);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (red_beat && !in_last) state_nxt = ACCUM;
      ACCUM:   if (red_beat && in_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Element-wise compare and select
  int                     ew_lg;
  logic [DATA_WIDTH-1:0]  ew_a, ew_b, ew_mask, ew_res;
  logic signed [XW-1:0]   ew_diff;
  logic [BE_WIDTH-1:0]    ew_lt, ew_eq;

  always_comb begin
    ew_res  = '0;
    ew_lt   = '0;
    ew_eq   = '0;
    ew_a    = '0;
    ew_b    = '0;
    ew_diff = '0;
    ew_lg   = elem_lg(sew);
    ew_mask = elem_mask(ew_lg);
    for (int k = 0; k < BE_WIDTH; k++) begin
      if (k < (DATA_WIDTH >> ew_lg)) begin
        ew_a    = elem_get(vec0, ew_lg, k);
        ew_b    = elem_get(vec1, ew_lg, k);
        ew_diff = elem_ext(ew_a, ew_lg, is_signed) - elem_ext(ew_b, ew_lg, is_signed);
        if (elem_active(in_be, ew_lg, k)) begin
          if (ew_diff[XW-1]) ew_lt = ew_lt | (BE_ONE << k);
          if ((ew_diff[DATA_WIDTH-1:0] & ew_mask) == '0) ew_eq = ew_eq | (BE_ONE << k);
          ew_res = ew_res | (((ew_diff[XW-1] ^ is_max) ? ew_a : ew_b) << (k << ew_lg));
        end else begin
          ew_res = ew_res | (ew_b << (k << ew_lg));
        end
      end
    end
  end

  // Pairwise tree over the active elements of vec0
  int                     rd_lg;
  logic [DATA_WIDTH-1:0]  rd_mask, rd_cand;
  logic                   rd_cand_ok;
  logic signed [XW-1:0]   tr_val [BE_WIDTH];
  logic                   tr_ok  [BE_WIDTH];

  always_comb begin
    rd_lg   = elem_lg(c_sew);
    rd_mask = elem_mask(rd_lg);
    for (int k = 0; k < BE_WIDTH; k++) begin
      tr_ok[k]  = (k < (DATA_WIDTH >> rd_lg)) && elem_active(in_be, rd_lg, k);
      tr_val[k] = elem_ext(elem_get(vec0, rd_lg, k), rd_lg, c_sgn);
    end
    for (int s = 1; s < BE_WIDTH; s = s * 2) begin
      for (int i = 0; i + s < BE_WIDTH; i = i + 2 * s) begin
        if (tr_ok[i+s] && (!tr_ok[i] || better(tr_val[i+s], tr_val[i], c_max))) begin
          tr_val[i] = tr_val[i+s];
          tr_ok[i]  = 1'b1;
        end
      end
    end
    rd_cand    = tr_val[0][DATA_WIDTH-1:0] & rd_mask;
    rd_cand_ok = tr_ok[0];
  end

  logic                  s1_valid, s1_red, s1_first, s1_last, s1_cand_ok, s1_max, s1_sgn;
  logic [SEW_WIDTH-1:0]  s1_sew;
  logic [DATA_WIDTH-1:0] s1_seed, s1_cand, s1_ew_res;
  logic [BE_WIDTH-1:0]   s1_lt, s1_eq;
  logic [DATA_WIDTH-1:0] acc, mg_base, mg_next;
  int                    mg_lg;

  // Stage 2 merge; acc closes a single-cycle loop so beats never stall
  always_comb begin
    mg_lg   = elem_lg(s1_sew);
    mg_base = s1_first ? s1_seed : acc;
    mg_next = mg_base;
    if (s1_cand_ok && better(elem_ext(s1_cand, mg_lg, s1_sgn), elem_ext(mg_base, mg_lg, s1_sgn), s1_max))
      mg_next = s1_cand;
  end

  logic                  s2_valid, s2_last;
  logic [DATA_WIDTH-1:0] s2_res;
  logic [BE_WIDTH-1:0]   s2_lt, s2_eq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lat_sew <= '0; lat_max <= 1'b0; lat_sgn <= 1'b0;
      s1_valid <= 1'b0; s1_red <= 1'b0; s1_first <= 1'b0; s1_last <= 1'b0;
      s1_cand_ok <= 1'b0; s1_max <= 1'b0; s1_sgn <= 1'b0; s1_sew <= '0;
      s1_seed <= '0; s1_cand <= '0; s1_ew_res <= '0; s1_lt <= '0; s1_eq <= '0;
      acc <= '0;
      s2_valid <= 1'b0; s2_last <= 1'b0; s2_res <= '0; s2_lt <= '0; s2_eq <= '0;
      out_valid <= 1'b0; out_last <= 1'b0; minmax_result <= '0; lt <= '0; equal <= '0;
    end else begin
      state <= state_nxt;
      if (red_beat && first_beat) begin
        lat_sew <= sew;
        lat_max <= is_max;
        lat_sgn <= is_signed;
      end
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_red     <= red_mode;
        s1_first   <= first_beat;
        s1_last    <= in_last;
        s1_cand_ok <= rd_cand_ok;
        s1_cand    <= rd_cand;
        s1_seed    <= vec1 & rd_mask;
        s1_sew     <= c_sew;
        s1_max     <= c_max;
        s1_sgn     <= c_sgn;
        s1_ew_res  <= ew_res;
        s1_lt      <= ew_lt;
        s1_eq      <= ew_eq;
      end
      if (s1_valid && s1_red) acc <= mg_next;
      s2_valid <= s1_valid && (!s1_red || s1_last);
      s2_last  <= s1_valid && s1_red && s1_last;
      if (s1_valid) begin
        s2_res <= s1_red ? mg_next : s1_ew_res;
        s2_lt  <= s1_red ? '0 : s1_lt;
        s2_eq  <= s1_red ? '0 : s1_eq;
      end
      out_valid <= s2_valid;
      out_last  <= s2_last;
      if (s2_valid) begin
        minmax_result <= s2_res;
        lt            <= s2_lt;
        equal         <= s2_eq;
      end
    end
  end
endmodule

// File: tb/tb_vminmax_reduce.sv
// tb/tb_vminmax_reduce.sv - self-checking bench for vminmax_reduce
// Honours VMINMAX_64BIT_EN when the design is built with it.
module tb_vminmax_reduce;
  logic        clk, rst_n, in_valid, in_last, red_mode, is_max, is_signed;
  logic [1:0]  sew;
  logic [63:0] vec0, vec1, minmax_result;
  logic [7:0]  in_be, lt, equal;
  logic        out_valid, out_last, busy;
  int          checks, errors;
  logic [63:0] r_v0 [8];
  logic [63:0] r_v1 [8];
  logic [7:0]  r_be [8];
  logic [63:0] e_res [32];
  logic [7:0]  e_lt [32];
  logic [7:0]  e_eq [32];

  vminmax_reduce dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .red_mode(red_mode),
    .is_max(is_max), .is_signed(is_signed), .sew(sew), .vec0(vec0), .vec1(vec1), .in_be(in_be),
    .out_valid(out_valid), .out_last(out_last), .minmax_result(minmax_result), .lt(lt),
    .equal(equal), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic int wbits(input int s);
`ifdef VMINMAX_64BIT_EN
    return 8 << s;
`else
    return (s >= 3) ? 32 : (8 << s);
`endif
  endfunction

  function automatic logic [63:0] field(input logic [63:0] v, input int w, input int k);
    logic [63:0] m;
    m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    return (v >> (k * w)) & m;
  endfunction

  // numeric value of a w-bit field as a wide signed integer
  function automatic logic signed [65:0] num(input logic [63:0] x, input int w, input logic sg);
    logic signed [65:0] v, one;
    one = 66'sd1;
    v = signed'({2'b00, x});
    if (sg && ((x >> (w - 1)) & 64'd1) != 64'd0) v = v - (one << w);
    return v;
  endfunction

  task automatic model_ew(input logic [63:0] a, input logic [63:0] b, input logic [7:0] be, input int s,
                          input logic mx, input logic sg,
                          output logic [63:0] res, output logic [7:0] l, output logic [7:0] e);
    int w;
    logic [63:0] ea, eb, pick;
    w = wbits(s);
    res = 64'd0; l = 8'd0; e = 8'd0;
    for (int k = 0; k < 64 / w; k++) begin
      ea = field(a, w, k);
      eb = field(b, w, k);
      pick = eb;
      if (be[k * w / 8]) begin
        l[k] = num(ea, w, sg) < num(eb, w, sg);
        e[k] = num(ea, w, sg) == num(eb, w, sg);
        if (mx ? (num(ea, w, sg) > num(eb, w, sg)) : (num(ea, w, sg) < num(eb, w, sg))) pick = ea;
      end
      res = res | (pick << (k * w));
    end
  endtask

  function automatic logic [63:0] model_red(input int n, input int s, input logic mx, input logic sg);
    int w;
    logic [63:0] best, v;
    w = wbits(s);
    best = field(r_v1[0], w, 0);
    for (int j = 0; j < n; j++)
      for (int k = 0; k < 64 / w; k++)
        if (r_be[j][k * w / 8]) begin
          v = field(r_v0[j], w, k);
          if (mx ? (num(v, w, sg) > num(best, w, sg)) : (num(v, w, sg) < num(best, w, sg))) best = v;
        end
    return best;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic last, input logic red, input logic mx, input logic sg,
                       input logic [1:0] s, input logic [63:0] a, input logic [63:0] b, input logic [7:0] be);
    in_valid = v; in_last = last; red_mode = red; is_max = mx; is_signed = sg;
    sew = s; vec0 = a; vec1 = b; in_be = be;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0, 8'd0);
  endtask

  task automatic run_ew(input string tag, input logic [63:0] a, input logic [63:0] b, input logic [7:0] be,
                        input int s, input logic mx, input logic sg,
                        output logic [63:0] r, output logic [7:0] l, output logic [7:0] e);
    logic [63:0] xr;
    logic [7:0]  xl, xe;
    model_ew(a, b, be, s, mx, sg, xr, xl, xe);
    drive(1'b1, 1'b0, 1'b0, mx, sg, 2'(s), a, b, be);
    @(negedge clk);
    idle();
    @(negedge clk);
    check({tag, "_early"}, out_valid, 64'd0);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 64'd1);
    check({tag, "_last"}, out_last, 64'd0);
    check({tag, "_res"}, minmax_result, xr);
    check({tag, "_lt"}, lt, xl);
    check({tag, "_eq"}, equal, xe);
    r = minmax_result; l = lt; e = equal;
  endtask

  task automatic run_red(input string tag, input int n, input int s, input logic mx, input logic sg,
                         input int bub, output logic [63:0] got);
    logic [63:0] expv;
    expv = model_red(n, s, mx, sg);
    for (int j = 0; j < n; j++) begin
      if (j == 0) drive(1'b1, n == 1, 1'b1, mx, sg, 2'(s), r_v0[j], r_v1[j], r_be[j]);
      else drive(1'b1, j == n - 1, 1'b1, 1'($urandom), 1'($urandom), 2'($urandom), r_v0[j], r_v1[j], r_be[j]);
      @(negedge clk);
      idle();
      check({tag, "_busy"}, busy, 64'(j < n - 1));
      check({tag, "_quiet"}, out_valid, 64'd0);
      if (j < n - 1) repeat ($urandom_range(0, bub)) @(negedge clk);
    end
    @(negedge clk);
    check({tag, "_early"}, out_valid, 64'd0);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 64'd1);
    check({tag, "_last"}, out_last, 64'd1);
    check({tag, "_res"}, minmax_result, expv);
    check({tag, "_lt"}, lt, 64'd0);
    check({tag, "_eq"}, equal, 64'd0);
    got = minmax_result;
    @(negedge clk);
    check({tag, "_once"}, out_valid, 64'd0);
  endtask

  initial begin
    logic [63:0] got, a, b, xr;
    logic [7:0]  gl, ge, be, xl, xe;
    int          s;
    logic        mx, sg;
    checks = 0; errors = 0;
    clk = 1'b0; rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 64'd0);
    check("rst_last", out_last, 64'd0);
    check("rst_busy", busy, 64'd0);
    check("rst_res", minmax_result, 64'd0);
    check("rst_lt", lt, 64'd0);
    check("rst_eq", equal, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_ew("tp1", 64'h8080808080808080, 64'h0101010101010101, 8'hFF, 0, 1'b0, 1'b1, got, gl, ge);
    check("tp1_res_k", got, 64'h8080808080808080);
    check("tp1_lt_k", gl, 64'hFF);
    check("tp1_eq_k", ge, 64'h00);
    run_ew("tp2", 64'hFFFF0001FFFF0001, 64'h0001FFFF0001FFFF, 8'hFF, 1, 1'b1, 1'b0, got, gl, ge);
    check("tp2_res_k", got, 64'hFFFFFFFFFFFFFFFF);
    check("tp2_lt_k", gl, 64'h05);
    run_ew("tie", 64'h1122334455667788, 64'h11AA3344556677FF, 8'h0F, 0, 1'b1, 1'b0, got, gl, ge);
    check("tie_res_k", got, 64'h11AA3344556677FF);
    check("tie_lt_k", gl, 64'h01);
    check("tie_eq_k", ge, 64'h0E);

    r_v0[0] = {32'd7, 32'hFFFF_FFFD}; r_v1[0] = {32'h1234_5678, 32'd5}; r_be[0] = 8'hFF;
    r_v0[1] = {32'hFFFF_FF38, 32'd100}; r_v1[1] = 64'($urandom); r_be[1] = 8'hF0;
    r_v0[2] = {32'd9, 32'd2}; r_v1[2] = 64'($urandom); r_be[2] = 8'hFF;
    run_red("tp3", 3, 2, 1'b1, 1'b1, 0, got);
    check("tp3_res_k", got, 64'h0000000000000009);

    for (int j = 0; j < 3; j++) begin
      r_v0[j] = {$urandom, $urandom}; r_v1[j] = {$urandom, 32'hDEADBEEF}; r_be[j] = 8'h00;
    end
    run_red("mask3", 3, 2, 1'b0, 1'b0, 1, got);
    check("mask3_res_k", got, 64'h00000000DEADBEEF);
    run_red("mask1", 1, 2, 1'b0, 1'b0, 0, got);
    check("mask1_res_k", got, 64'h00000000DEADBEEF);

    r_v0[0] = {32'd50, 32'd60}; r_v1[0] = 64'd40; r_be[0] = 8'hFF;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, r_v0[0], r_v1[0], r_be[0]);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, r_v0[0], r_v1[0], r_be[0]);
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", out_valid, 64'd0);
    check("rstmid_busy", busy, 64'd0);
    check("rstmid_res", minmax_result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstmid_flush", out_valid, 64'd0);
    end
    r_v0[0] = {32'd1, 32'd3}; r_v1[0] = {32'($urandom), 32'd2}; r_be[0] = 8'hFF;
    run_red("post_rst", 1, 2, 1'b0, 1'b0, 0, got);
    check("post_rst_res_k", got, 64'd1);

`ifdef VMINMAX_64BIT_EN
    run_ew("sew64", 64'h8000000000000000, 64'd1, 8'hFF, 3, 1'b0, 1'b1, got, gl, ge);
    check("sew64_lt_k", gl, 64'h01);
    check("sew64_res_k", got, 64'h8000000000000000);
`else
    for (int i = 0; i < 3; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; be = 8'($urandom);
      mx = 1'($urandom); sg = 1'($urandom);
      model_ew(a, b, be, 2, mx, sg, xr, xl, xe);
      run_ew("sew3", a, b, be, 3, mx, sg, got, gl, ge);
      check("sew3_as2_res", got, xr);
      check("sew3_as2_lt", gl, xl);
    end
`endif

    for (int t = 0; t < 6; t++) begin
      for (int j = 0; j < 4; j++) begin
        r_v0[j] = {$urandom, $urandom}; r_v1[j] = {$urandom, $urandom};
        r_be[j] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      end
      run_red("rand_red", int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 2, got);
    end

    for (int i = 0; i < 27; i++) begin
      if (i >= 3) begin
        check("burst_valid", out_valid, 64'd1);
        check("burst_res", minmax_result, e_res[i-3]);
        check("burst_lt", lt, e_lt[i-3]);
        check("burst_eq", equal, e_eq[i-3]);
      end
      if (i < 24) begin
        a = {$urandom, $urandom};
        b = ($urandom_range(0, 3) == 0) ? a ^ 64'(8'($urandom)) : {$urandom, $urandom};
        be = 8'($urandom); s = int'($urandom_range(0, 3)); mx = 1'($urandom); sg = 1'($urandom);
        model_ew(a, b, be, s, mx, sg, xr, xl, xe);
        e_res[i] = xr; e_lt[i] = xl; e_eq[i] = xe;
        drive(1'b1, 1'($urandom), 1'b0, mx, sg, 2'(s), a, b, be);
      end else begin
        idle();
      end
      @(negedge clk);
    end
    check("burst_tail", out_valid, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
